// File: rtl/morra_ref_if.sv
// Referee bus between the Morra match driver (master) and the referee (slave).
interface morra_ref_if;
  // No valid/ready: START is a one-cycle strobe carrying cfg on P1/P2, a move
  // pair is valid only in the cycle it is non-zero, ROUND is trusted only in the
  // last cycle of each slot, and GAME != 00 in any cycle ends the match.
  logic       START;
  logic [1:0] P1;
  logic [1:0] P2;
  logic [1:0] ROUND;
  logic [1:0] GAME;

  modport master (output START, P1, P2, input ROUND, GAME);
  modport slave  (input START, P1, P2, output ROUND, GAME);
endinterface

// File: rtl/morra_match_driver.sv
// Drives a Morra match against an external referee: START, then LFSR-generated
// move pairs in fixed-length slots, tallying ROUND outcomes until GAME or timeout.
module morra_match_driver #(
  parameter logic [7:0]  SEED1    = 8'hA5,
  parameter logic [7:0]  SEED2    = 8'h3C,
  parameter int unsigned RESP_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [3:0]  cfg_rounds,
  morra_ref_if.master bus,
  output logic        busy,
  output logic        done,
  output logic [1:0]  result,
  output logic        timeout,
  output logic [3:0]  p1_wins,
  output logic [3:0]  p2_wins,
  output logic [3:0]  draws,
  output logic [3:0]  invalids,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_PLAY, S_DONE} state_t;

  localparam logic [2:0] LAST      = 3'(RESP_LAT);
  localparam logic [7:0] SEED1_EFF = (SEED1 == 8'h00) ? 8'h01 : SEED1;
  localparam logic [7:0] SEED2_EFF = (SEED2 == 8'h00) ? 8'h01 : SEED2;

  state_t     state, state_nx;
  logic [7:0] lfsr1, lfsr2, lfsr1_nx, lfsr2_nx;
  logic [1:0] forbid1, forbid2, forbid1_nx, forbid2_nx;
  logic [1:0] move1, move2, move1_nx, move2_nx;
  logic [2:0] slot_cyc;
  logic [4:0] slot_cnt;
  logic       enter_init, drive_pair, sample, capture, set_timeout;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [1:0] legal_move(input logic [1:0] cand, input logic [1:0] forbid);
    logic [1:0] m;
    m = (cand == 2'b00) ? 2'b01 : cand;
    if (m == forbid) m = (m == 2'b11) ? 2'b01 : m + 2'b01;
    return m;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'h1;
  endfunction

  always_comb begin
    state_nx    = state;
    enter_init  = 1'b0;
    drive_pair  = 1'b0;
    sample      = 1'b0;
    capture     = 1'b0;
    set_timeout = 1'b0;
    case (state)
      S_IDLE: if (go) begin
        state_nx   = S_INIT;
        enter_init = 1'b1;
      end
      S_INIT: begin
        state_nx   = S_PLAY;
        drive_pair = 1'b1;
      end
      S_PLAY: begin
        sample = (slot_cyc == LAST);
        // A live GAME code wins over the timeout and the next pair.
        if (bus.GAME != 2'b00) begin
          state_nx = S_DONE;
          capture  = 1'b1;
        end else if (sample && slot_cnt == 5'd30) begin
          state_nx    = S_DONE;
          set_timeout = 1'b1;
        end else if (sample) begin
          drive_pair = 1'b1;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // The forbid update is forwarded so the very next pair already avoids
  // repeating a move that just won.
  always_comb begin
    forbid1_nx = forbid1;
    forbid2_nx = forbid2;
    if (sample) begin
      case (bus.ROUND)
        2'b01:   begin forbid1_nx = move1; forbid2_nx = 2'b00; end
        2'b10:   begin forbid2_nx = move2; forbid1_nx = 2'b00; end
        2'b11:   begin forbid1_nx = 2'b00; forbid2_nx = 2'b00; end
        default: ;
      endcase
    end
    lfsr1_nx = lfsr_step(lfsr1);
    lfsr2_nx = lfsr_step(lfsr2);
    move1_nx = legal_move(lfsr1_nx[1:0], forbid1_nx);
    move2_nx = legal_move(lfsr2_nx[1:0], forbid2_nx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bus.START <= 1'b0;
      bus.P1    <= 2'b00;
      bus.P2    <= 2'b00;
      lfsr1     <= SEED1_EFF;
      lfsr2     <= SEED2_EFF;
      forbid1   <= 2'b00;
      forbid2   <= 2'b00;
      move1     <= 2'b00;
      move2     <= 2'b00;
      slot_cyc  <= 3'd0;
      slot_cnt  <= 5'd0;
      result    <= 2'b00;
      timeout   <= 1'b0;
      p1_wins   <= 4'd0;
      p2_wins   <= 4'd0;
      draws     <= 4'd0;
      invalids  <= 4'd0;
    end else begin
      state     <= state_nx;
      bus.START <= enter_init;
      if (enter_init) begin
        bus.P1 <= cfg_rounds[3:2];
        bus.P2 <= cfg_rounds[1:0];
      end else if (drive_pair) begin
        bus.P1 <= move1_nx;
        bus.P2 <= move2_nx;
      end else begin
        bus.P1 <= 2'b00;
        bus.P2 <= 2'b00;
      end

      if (enter_init) begin
        forbid1  <= 2'b00;
        forbid2  <= 2'b00;
        slot_cyc <= 3'd0;
        slot_cnt <= 5'd0;
        result   <= 2'b00;
        timeout  <= 1'b0;
        p1_wins  <= 4'd0;
        p2_wins  <= 4'd0;
        draws    <= 4'd0;
        invalids <= 4'd0;
      end else begin
        forbid1 <= forbid1_nx;
        forbid2 <= forbid2_nx;
        if (sample) begin
          case (bus.ROUND)
            2'b00: invalids <= sat_inc(invalids);
            2'b01: p1_wins  <= sat_inc(p1_wins);
            2'b10: p2_wins  <= sat_inc(p2_wins);
            2'b11: draws    <= sat_inc(draws);
            default: ;
          endcase
        end
        if (capture) result <= bus.GAME;
        if (set_timeout) begin
          timeout <= 1'b1;
          result  <= 2'b00;
        end
        if (drive_pair) begin
          lfsr1    <= lfsr1_nx;
          lfsr2    <= lfsr2_nx;
          move1    <= move1_nx;
          move2    <= move2_nx;
          slot_cyc <= 3'd0;
        end else if (state == S_PLAY) begin
          slot_cyc <= slot_cyc + 3'd1;
        end
        if (sample && state_nx == S_PLAY) slot_cnt <= slot_cnt + 5'd1;
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: doc/morra_match_driver.md
MORRA_MATCH_DRIVER -- requirements
Module: morra_match_driver

Interface
REQ-001 SHALL have parameter SEED1, default 8'hA5: initial value of the player-1 move LFSR.
REQ-002 SHALL have parameter SEED2, default 8'h3C: initial value of the player-2 move LFSR.
REQ-003 SHALL have parameter RESP_LAT, default 2: cycles from driving a move pair to a valid referee ROUND, legal range 1..7.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port go  in  1  single-cycle request to start a match.
REQ-007 SHALL have port cfg_rounds  in  4  extra-rounds code sent to the referee with START.
REQ-008 SHALL have port ROUND  in  2  referee round outcome: 00 invalid, 01 P1, 10 P2, 11 draw.
REQ-009 SHALL have port GAME  in  2  referee game outcome: 00 running, 01 P1, 10 P2, 11 draw.
REQ-010 SHALL have port START  out  1  referee start strobe.
REQ-011 SHALL have ports P1, P2  out  2 each  moves: 00 none, 01/10/11 legal moves.
REQ-012 SHALL have ports busy  out  1  match in progress, and done  out  1  one-cycle end-of-match pulse.
REQ-013 SHALL have ports result  out  2  captured GAME code, and timeout  out  1  match abandoned.
REQ-014 SHALL have ports p1_wins, p2_wins, draws, invalids  out  4 each  per-match round counters.

Function
REQ-015 SHALL implement states IDLE, INIT, PLAY, DONE.
REQ-016 SHALL move IDLE->INIT on go=1; go in any other state SHALL be ignored.
REQ-017 INIT SHALL last exactly 1 cycle with START=1, P1=cfg_rounds[3:2], P2=cfg_rounds[1:0]; it SHALL clear all counters, result, timeout and forbid registers.
REQ-018 PLAY SHALL run in slots of RESP_LAT+1 cycles: slot cycle 0 drives the generated pair, and cycles 1..RESP_LAT drive P1=P2=00.
REQ-019 SHALL sample ROUND only at the last cycle of each slot; ROUND in any other cycle SHALL be ignored.
REQ-020 Move generation: each player has an 8-bit Fibonacci LFSR, taps 8,6,5,4, advanced once per slot at slot cycle 0; candidate = lfsr[1:0], and 00 SHALL map to 01.
REQ-021 Legality: if the candidate equals the player's forbid move, it SHALL rotate 01->10->11->01 once.
REQ-022 Forbid update at sample: ROUND=01 sets forbid1 to the slot's P1 move and clears forbid2; ROUND=10 sets forbid2 to the slot's P2 move and clears forbid1; 11 clears both; 00 leaves both unchanged.
REQ-023 Counters SHALL increment at sample per ROUND value and saturate at 15.
REQ-024 In PLAY, GAME!=00 in any cycle SHALL capture result=GAME and enter DONE on the next edge; this takes precedence over a same-cycle sample, whose counter update still applies.
REQ-025 If 31 slots complete with GAME=00, timeout SHALL be set, result SHALL be 00, and the FSM SHALL enter DONE.
REQ-026 DONE SHALL last 1 cycle with done=1 and then return to IDLE; result, timeout and counters SHALL hold until the next INIT.
REQ-027 busy SHALL be 1 in INIT, PLAY and DONE, and 0 in IDLE.
REQ-028 START, P1 and P2 SHALL be registered outputs and 00/0 outside INIT and PLAY slot cycle 0.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE and set all outputs to 0.
REQ-030 rst_n=0 SHALL clear the forbid registers and the slot and timeout counters.
REQ-031 rst_n=0 SHALL load the LFSRs with SEED1/SEED2, with a seed of 0 replaced by 8'h01.
REQ-032 Reset asserted mid-match SHALL abandon the match without a done pulse.

Verification
REQ-033 Reset: assert rst_n=0 mid-PLAY -> outputs 0 immediately; after release busy=0, and P1/P2/START=0 until go.
REQ-034 Start: cfg_rounds=4'b0110, go=1 -> the next cycle has START=1, P1=01, P2=10; PLAY follows with a first pair at the following cycle.
REQ-035 Stub referee returns ROUND=01 at every sample and GAME=01 after the 4th sample -> p1_wins=4, result=01, done pulse one cycle after GAME, and no P1 repeat of the last winning move.
REQ-036 Stub returns ROUND=11 for 31 slots and GAME=00 -> draws=15 (saturated), timeout=1, result=00, done=1.
REQ-037 RESP_LAT=1: ROUND=10 driven during a filler cycle is ignored, and only slot-end samples change counters.
REQ-038 go pulsed during PLAY and during DONE -> no START, and no state change beyond the normal sequence.
